// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state type and sizing helper for the instruction/load-store
// memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic {
    PRIO_LS = 1'b0,
    PRIO_IF = 1'b1
  } arb_state_e;

  // Starve counter must hold STARVE_MAX and is never narrower than 3 bits.
  function automatic int starve_cnt_w(input int max_cnt);
    int w;
    w = $clog2(max_cnt + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared memory port around the
// arbiter. The slave modport is the arbiter's view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Handshake: a request transfers in the cycle where *_req_valid && *_req_ready.
  // Ready is a same-cycle grant, so valid must not wait on ready. Responses are
  // single-cycle pulses one cycle after transfer and cannot be back-pressured.
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic              ls_req_valid;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [MASK_W-1:0] ls_mask;
  logic              ls_req_ready;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              ls_rsp_err;

  logic              mem_request;
  logic              mem_we_re;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [MASK_W-1:0] mem_mask;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_we, ls_addr, ls_wdata, ls_mask,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
    output mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
    input  mem_data_out
  );

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_we, ls_addr, ls_wdata, ls_mask,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
    input  mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
    output mem_data_out
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch vs load/store) onto a single-cycle memory,
// load/store-first with a starvation limit that forces one fetch through.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output arb_state_e   o_dbg_state
);

  localparam int                CNT_W   = starve_cnt_w(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_if_grant;
  logic              w_ls_grant;
  logic              w_ls_null_store;

  logic              w_mem_request;
  logic              w_mem_we_re;
  logic [ADDR_W-1:0] w_mem_address;
  logic [DATA_W-1:0] w_mem_data_in;
  logic [MASK_W-1:0] w_mem_mask;

  logic              r_if_rsp_valid;
  logic [DATA_W-1:0] r_if_rsp_data;
  logic              r_ls_rsp_valid;
  logic [DATA_W-1:0] r_ls_rsp_data;
  logic              r_ls_rsp_err;

  // State register: FSM state and starve counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PRIO_LS;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_cnt_nxt   = r_starve_cnt;
    w_state_nxt = r_state;
    if (w_if_grant || !bus.if_req_valid) begin
      w_cnt_nxt = '0;
    end else if (w_ls_grant && (r_starve_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_starve_cnt + CNT_W'(1);
    end
    unique case (r_state)
      PRIO_LS: if (w_cnt_nxt == CNT_MAX) w_state_nxt = PRIO_IF;
      PRIO_IF: if (w_if_grant || !bus.if_req_valid) w_state_nxt = PRIO_LS;
      default: w_state_nxt = PRIO_LS;
    endcase
  end

  // Output logic: grants are gated by rst_n so nothing reaches memory in reset.
  always_comb begin
    w_if_grant = 1'b0;
    w_ls_grant = 1'b0;
    if (rst_n) begin
      if (r_state == PRIO_IF) begin
        w_if_grant = bus.if_req_valid;
        w_ls_grant = bus.ls_req_valid && !bus.if_req_valid;
      end else begin
        w_ls_grant = bus.ls_req_valid;
        w_if_grant = bus.if_req_valid && !bus.ls_req_valid;
      end
    end
  end

  // A store with an empty byte mask still consumes the slot but never touches memory.
  assign w_ls_null_store = w_ls_grant && bus.ls_we && (bus.ls_mask == '0);

  always_comb begin
    w_mem_request = 1'b0;
    w_mem_we_re   = 1'b0;
    w_mem_address = '0;
    w_mem_data_in = '0;
    w_mem_mask    = '0;
    if (w_if_grant) begin
      w_mem_request = 1'b1;
      w_mem_address = bus.if_addr;
    end else if (w_ls_grant && !w_ls_null_store) begin
      w_mem_request = 1'b1;
      w_mem_we_re   = bus.ls_we;
      w_mem_address = bus.ls_addr;
      if (bus.ls_we) begin
        w_mem_data_in = bus.ls_wdata;
        w_mem_mask    = bus.ls_mask;
      end
    end
  end

  // Responses: read data captured in the grant cycle; data holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_ls_rsp_valid <= 1'b0;
      r_ls_rsp_data  <= '0;
      r_ls_rsp_err   <= 1'b0;
    end else begin
      r_if_rsp_valid <= w_if_grant;
      r_ls_rsp_valid <= w_ls_grant;
      r_ls_rsp_err   <= w_ls_null_store;
      if (w_if_grant) r_if_rsp_data <= bus.mem_data_out;
      if (w_ls_grant) r_ls_rsp_data <= bus.ls_we ? '0 : bus.mem_data_out;
    end
  end

  assign bus.if_req_ready = w_if_grant;
  assign bus.ls_req_ready = w_ls_grant;
  assign bus.if_rsp_valid = r_if_rsp_valid;
  assign bus.if_rsp_data  = r_if_rsp_data;
  assign bus.ls_rsp_valid = r_ls_rsp_valid;
  assign bus.ls_rsp_data  = r_ls_rsp_data;
  assign bus.ls_rsp_err   = r_ls_rsp_err;
  assign bus.mem_request  = w_mem_request;
  assign bus.mem_we_re    = w_mem_we_re;
  assign bus.mem_address  = w_mem_address;
  assign bus.mem_data_in  = w_mem_data_in;
  assign bus.mem_mask     = w_mem_mask;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// long randomized run checked every cycle against a behavioural model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  arb_state_e    dbg_state;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- memory block ----------------
  logic [31:0] mem_arr [256];
  assign bus.mem_data_out = mem_arr[bus.mem_address];

  function automatic logic [31:0] init_word(input int a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h05:   return 32'hAABBCCDD;
      default: return 32'h5A000000 ^ (32'(a) * 32'h00010203);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_request && bus.mem_we_re)
        for (int b = 0; b < 4; b++)
          if (bus.mem_mask[b]) mem_arr[bus.mem_address][b*8 +: 8] <= bus.mem_data_in[b*8 +: 8];
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_if(input logic v, input logic [7:0] a);
    bus.if_req_valid = v;
    bus.if_addr      = a;
  endtask

  task automatic drive_ls(input logic v, input logic we, input logic [7:0] a,
                          input logic [31:0] wd, input logic [3:0] m);
    bus.ls_req_valid = v;
    bus.ls_we        = we;
    bus.ls_addr      = a;
    bus.ls_wdata     = wd;
    bus.ls_mask      = m;
  endtask

  task automatic drive_idle();
    drive_if(1'b0, 8'h00);
    drive_ls(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Model view: IF gets priority only after STARVE_MAX back-to-back LS wins
  // during which IF was asking; expected responses go through queues.
  logic [31:0] sh_mem [256];
  logic [31:0] if_exp_q [$];
  logic [31:0] ls_exp_q [$];
  logic        exp_if_v, exp_ls_v, exp_ls_e;
  logic [31:0] if_hold, ls_hold;
  int          streak, if_wait, ls_wait;
  logic        g_if, g_ls, null_st;
  logic        e_req, e_we;
  logic [7:0]  e_addr;
  logic [31:0] e_din;
  logic [3:0]  e_mask;

  initial for (int i = 0; i < 256; i++) sh_mem[i] = init_word(i);

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_if_ready",  bus.if_req_ready, 0);
      check("rst_ls_ready",  bus.ls_req_ready, 0);
      check("rst_mem_req",   bus.mem_request,  0);
      check("rst_mem_we",    bus.mem_we_re,    0);
      check("rst_mem_addr",  bus.mem_address,  0);
      check("rst_mem_din",   bus.mem_data_in,  0);
      check("rst_mem_mask",  bus.mem_mask,     0);
      check("rst_if_rsp_v",  bus.if_rsp_valid, 0);
      check("rst_ls_rsp_v",  bus.ls_rsp_valid, 0);
      check("rst_if_rsp_d",  bus.if_rsp_data,  0);
      check("rst_ls_rsp_d",  bus.ls_rsp_data,  0);
      check("rst_ls_err",    bus.ls_rsp_err,   0);
      streak = 0; if_wait = 0; ls_wait = 0;
      exp_if_v = 1'b0; exp_ls_v = 1'b0; exp_ls_e = 1'b0;
      if_hold = '0; ls_hold = '0;
      if_exp_q.delete(); ls_exp_q.delete();
    end else begin
      check("if_rsp_valid", bus.if_rsp_valid, exp_if_v);
      if (exp_if_v && if_exp_q.size() > 0) if_hold = if_exp_q.pop_front();
      check("if_rsp_data", bus.if_rsp_data, if_hold);
      check("ls_rsp_valid", bus.ls_rsp_valid, exp_ls_v);
      if (exp_ls_v && ls_exp_q.size() > 0) ls_hold = ls_exp_q.pop_front();
      check("ls_rsp_data", bus.ls_rsp_data, ls_hold);
      check("ls_rsp_err", bus.ls_rsp_err, exp_ls_v ? exp_ls_e : 1'b0);

      g_if    = bus.if_req_valid && ((streak >= STARVE_MAX) || !bus.ls_req_valid);
      g_ls    = bus.ls_req_valid && !g_if;
      null_st = g_ls && bus.ls_we && (bus.ls_mask == 4'h0);

      e_req = 1'b0; e_we = 1'b0; e_addr = 8'h0; e_din = 32'h0; e_mask = 4'h0;
      if (g_if) begin
        e_req = 1'b1; e_addr = bus.if_addr;
      end else if (g_ls && !null_st) begin
        e_req = 1'b1; e_we = bus.ls_we; e_addr = bus.ls_addr;
        if (bus.ls_we) begin e_din = bus.ls_wdata; e_mask = bus.ls_mask; end
      end
      check("if_req_ready", bus.if_req_ready, g_if);
      check("ls_req_ready", bus.ls_req_ready, g_ls);
      check("mem_request",  bus.mem_request,  e_req);
      check("mem_we_re",    bus.mem_we_re,    e_we);
      check("mem_address",  bus.mem_address,  e_addr);
      check("mem_data_in",  bus.mem_data_in,  e_din);
      check("mem_mask",     bus.mem_mask,     e_mask);

      if (bus.if_req_valid && !bus.if_req_ready) if_wait++; else if_wait = 0;
      if (bus.ls_req_valid && !bus.ls_req_ready) ls_wait++; else ls_wait = 0;
      if (bus.if_req_valid) check("if_wait_bound", 32'(if_wait <= STARVE_MAX), 1);
      if (bus.ls_req_valid) check("ls_wait_bound", 32'(ls_wait <= STARVE_MAX), 1);

      exp_if_v = g_if;
      exp_ls_v = g_ls;
      exp_ls_e = null_st;
      if (g_if) if_exp_q.push_back(sh_mem[bus.if_addr]);
      if (g_ls) ls_exp_q.push_back(bus.ls_we ? 32'h0 : sh_mem[bus.ls_addr]);
      if (g_ls && bus.ls_we)
        for (int b = 0; b < 4; b++)
          if (bus.ls_mask[b]) sh_mem[bus.ls_addr][b*8 +: 8] = bus.ls_wdata[b*8 +: 8];

      if (g_if || !bus.if_req_valid) streak = 0;
      else if (g_ls) streak++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, PRIO_LS);
    next_cycle();
    rst_n = 1'b1;

    // LS and IF collide in PRIO_LS: LS first, IF the next cycle.
    drive_if(1'b1, 8'h20);
    drive_ls(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("t1_ls_ready", bus.ls_req_ready, 1);
    check("t1_if_ready", bus.if_req_ready, 0);
    check("t1_mem_addr", bus.mem_address, 32'h10);
    next_cycle();
    drive_ls(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    check("t1_ls_rsp_v", bus.ls_rsp_valid, 1);
    check("t1_ls_rsp_d", bus.ls_rsp_data, 32'hDEADBEEF);
    check("t1_if_ready2", bus.if_req_ready, 1);
    check("t1_mem_addr2", bus.mem_address, 32'h20);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("t1_if_rsp_v", bus.if_rsp_valid, 1);
    check("t1_if_rsp_d", bus.if_rsp_data, init_word(8'h20));
    next_cycle();

    // Both ports saturated: LS x STARVE_MAX, then one IF, repeating.
    for (int i = 0; i < 12; i++) begin
      drive_if(1'b1, 8'($urandom_range(0, 255)));
      drive_ls(1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0, 4'h0);
      @(negedge clk);
      check("t2_if_grant", bus.if_req_ready, (i == STARVE_MAX) || (i == 2*STARVE_MAX + 1));
      check("t2_ls_grant", bus.ls_req_ready, !((i == STARVE_MAX) || (i == 2*STARVE_MAX + 1)));
      next_cycle();
    end
    drive_idle();
    next_cycle();

    // Partial store then read-back.
    drive_ls(1'b1, 1'b1, 8'h05, 32'h11223344, 4'b0011);
    @(negedge clk);
    check("t3_mem_we", bus.mem_we_re, 1);
    check("t3_mem_mask", bus.mem_mask, 4'b0011);
    check("t3_mem_din", bus.mem_data_in, 32'h11223344);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("t3_ack_v", bus.ls_rsp_valid, 1);
    check("t3_ack_err", bus.ls_rsp_err, 0);
    check("t3_ack_d", bus.ls_rsp_data, 0);
    next_cycle();
    drive_ls(1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("t3_readback", bus.ls_rsp_data, 32'hAABB3344);
    next_cycle();

    // Empty-mask store: slot consumed, nothing reaches memory, error ack.
    drive_ls(1'b1, 1'b1, 8'h06, 32'hFFFFFFFF, 4'b0000);
    drive_if(1'b1, 8'h07);
    @(negedge clk);
    check("t4_mem_req", bus.mem_request, 0);
    check("t4_ls_ready", bus.ls_req_ready, 1);
    check("t4_if_ready", bus.if_req_ready, 0);
    next_cycle();
    drive_if(1'b0, 8'h00);
    drive_ls(1'b1, 1'b0, 8'h06, 32'h0, 4'h0);
    @(negedge clk);
    check("t4_err_v", bus.ls_rsp_valid, 1);
    check("t4_err", bus.ls_rsp_err, 1);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("t4_unchanged", bus.ls_rsp_data, init_word(8'h06));
    check("t4_err_clr", bus.ls_rsp_err, 0);
    next_cycle();

    // Fetch stream over addresses 0..7.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive_if(1'b1, 8'(i)); else drive_if(1'b0, 8'h00);
      @(negedge clk);
      if (i > 0) begin
        check("t5_if_rsp_v", bus.if_rsp_valid, 1);
        check("t5_if_rsp_d", bus.if_rsp_data, (i - 1 == 5) ? 32'hAABB3344 : init_word(i - 1));
      end
      next_cycle();
    end

    // Reset right after a load grant drops the pending response.
    drive_ls(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    drive_if(1'b1, 8'h21);
    @(negedge clk);
    check("t6_ls_ready", bus.ls_req_ready, 1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_no_pulse", bus.ls_rsp_valid, 0);
    check("t6_mem_req", bus.mem_request, 0);
    check("t6_ready", {bus.if_req_ready, bus.ls_req_ready}, 0);
    next_cycle();
    drive_idle();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_ls_v", bus.ls_rsp_valid, 0);
    check("t6_post_if_v", bus.if_rsp_valid, 0);
    check("t6_state", dbg_state, PRIO_LS);
    next_cycle();

    // Randomized traffic over a small address window to force RAW hits.
    for (int i = 0; i < 3000; i++) begin
      drive_if(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 15)));
      drive_ls(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      next_cycle();
    end
    drive_idle();
    repeat (3) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive LS grants allowed while IF waits before IF is forced.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_req_valid  in  1  instruction fetch request.
REQ-005 if_addr  in  8  fetch word address.
REQ-006 if_req_ready  out  1  fetch accepted this cycle (combinational grant).
REQ-007 if_rsp_valid / if_rsp_data  out  1 / 32  fetch response.
REQ-008 ls_req_valid, ls_we, ls_addr, ls_wdata, ls_mask  in  1,1,8,32,4  load/store request; ls_we=1 store.
REQ-009 ls_req_ready  out  1  load/store accepted this cycle.
REQ-010 ls_rsp_valid / ls_rsp_data / ls_rsp_err  out  1 / 32 / 1  load/store response or store ack.
REQ-011 mem_request, mem_we_re, mem_address, mem_data_in, mem_mask  out  1,1,8,32,4  shared memory port.
REQ-012 mem_data_out  in  32  combinational memory read data.

Function
REQ-013 At most one request SHALL be granted per cycle; granted = valid && ready in that cycle.
REQ-014 FSM states: PRIO_LS (reset state), PRIO_IF.
REQ-015 PRIO_LS: LS granted if ls_req_valid, else IF granted if if_req_valid.
REQ-016 PRIO_IF: IF granted if if_req_valid, else LS if ls_req_valid.
REQ-017 Starve counter (3 bits min, sized for STARVE_MAX): +1 on each LS grant while if_req_valid=1; cleared on any IF grant or when if_req_valid=0.
REQ-018 PRIO_LS -> PRIO_IF when counter reaches STARVE_MAX at a clock edge; PRIO_IF -> PRIO_LS after the next IF grant, or when if_req_valid=0.
REQ-019 Grant cycle: mem_request=1, mem_address=granted address; mem_we_re=ls_we for LS, 0 for IF; mem_data_in/mem_mask = ls_wdata/ls_mask for LS stores, else 0.
REQ-020 No grant: all mem_* outputs 0.
REQ-021 Read data SHALL be sampled from mem_data_out in the grant cycle and registered; response valid exactly 1 cycle after grant, single-cycle pulse, no backpressure.
REQ-022 Store grant SHALL produce ls_rsp_valid=1 one cycle later with ls_rsp_data=0.
REQ-023 Store with ls_mask=4'b0000: accepted (ls_req_ready=1) but mem_request=0 that cycle; next cycle ls_rsp_valid=1, ls_rsp_err=1; IF may NOT be granted in its place that cycle.
REQ-024 ls_rsp_err=0 for all other responses.
REQ-025 rsp_data outputs SHALL hold their last value when rsp_valid=0.
REQ-026 Back-to-back grants SHALL be sustained: one response per cycle, in grant order per port.
REQ-027 Simultaneous valid on both ports with loser held: loser granted no later than STARVE_MAX+1 cycles after first asserting.

Reset
REQ-028 rst_n low SHALL immediately force: state PRIO_LS, counter 0, all rsp_valid 0, rsp_data 0, ls_rsp_err 0.
REQ-029 During reset, ready outputs and all mem_* outputs SHALL be 0 (no memory write can occur).
REQ-030 A response pending when reset asserts SHALL be dropped; none emitted after release.

Structure
REQ-031 Shared package holds ADDR_W=8, DATA_W=32, MASK_W=4 and the FSM state enum.
REQ-032 Single module; no sub-module needed; connects directly to the existing memory block ports.

Verification
REQ-033 LS load addr 0x10 (mem=0xDEADBEEF) and IF addr 0x20 same cycle, state PRIO_LS -> LS granted, ls_rsp_data=0xDEADBEEF next cycle; IF granted following cycle.
REQ-034 LS valid continuously, IF valid continuously, STARVE_MAX=4 -> grants LS,LS,LS,LS,IF,LS...; counter clears after IF grant.
REQ-035 Store addr 0x05, wdata 0x11223344, mask 4'b0011 -> next-cycle ack err=0; later load 0x05 returns upper bytes unchanged, low half 0x3344.
REQ-036 Store mask 4'b0000 -> mem_request=0, ls_rsp_valid=1 with ls_rsp_err=1 next cycle, memory unchanged.
REQ-037 Assert rst_n low in the cycle after a load grant -> no rsp_valid pulse, mem_* all 0, state PRIO_LS after release.
REQ-038 IF only, valid 8 consecutive cycles, addrs 0..7 -> 8 consecutive if_rsp_valid pulses, data in address order.
